noc_outport_arbiter: RTL and testbench

Output-port scheduler for one NoC router output channel. Arbitrates NUM_PORTS input-port requesters round-robin with wormhole packet locking, so a granted requester owns the channel until its tail flit. Gates every transfer on a downstream credit count held in an embedded credit counter. Sits between the router's input buffers/crossbar select and the output link.

---
 rtl/noc_outport_arbiter_pkg.sv | 23 ++
 rtl/noc_outport_arbiter_if.sv | 35 +++
 rtl/noc_outport_arbiter_credit_counter.sv | 46 ++++
 rtl/noc_outport_arbiter.sv | 118 +++++++++++
 tb/tb_noc_outport_arbiter.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/noc_outport_arbiter_pkg.sv
// Shared definitions for the NoC output-port scheduler.
//   NOC_NUM_PORTS : default requester count (N, E, S, W, local)
//   port_idx_t    : index into the requester vector
//   arb_state_t   : wormhole arbiter state
//   PORT_*        : named requester indices
package noc_pkg;

  localparam int NOC_NUM_PORTS = 5;

  typedef logic [$clog2(NOC_NUM_PORTS)-1:0] port_idx_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  localparam port_idx_t PORT_N     = 3'd0;
  localparam port_idx_t PORT_E     = 3'd1;
  localparam port_idx_t PORT_S     = 3'd2;
  localparam port_idx_t PORT_W     = 3'd3;
  localparam port_idx_t PORT_LOCAL = 3'd4;

endpackage

// File: rtl/noc_outport_arbiter_if.sv
// Handshake bundle between the router input side and one output-port
// scheduler.
//   req_i/tail_i/credit_ret_i : driven by input buffers / downstream link
//   grant_o/flit_sent_o       : crossbar select and transfer strobe
//   locked_o                  : channel owned by a packet in progress
//   credit_*/overflow_err_o   : downstream credit state
// Modports: master = requester/link side, slave = the scheduler.
interface noc_outport_arbiter_if #(
  parameter int NUM_PORTS = 5,
  parameter int BUF_DEPTH = 4
);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [NUM_PORTS-1:0] req_i;
  logic [NUM_PORTS-1:0] tail_i;
  logic                 credit_ret_i;
  logic [NUM_PORTS-1:0] grant_o;
  logic                 flit_sent_o;
  logic                 locked_o;
  logic                 credit_en_o;
  logic [CW-1:0]        credit_cnt_o;
  logic                 overflow_err_o;

  modport master (
    output req_i, tail_i, credit_ret_i,
    input  grant_o, flit_sent_o, locked_o, credit_en_o, credit_cnt_o,
           overflow_err_o
  );

  modport slave (
    input  req_i, tail_i, credit_ret_i,
    output grant_o, flit_sent_o, locked_o, credit_en_o, credit_cnt_o,
           overflow_err_o
  );
endinterface

// File: rtl/noc_outport_arbiter_credit_counter.sv
// Saturating downstream credit counter.
//   clk, rst       : clock, asynchronous active-low reset
//   incr_i         : downstream returned one slot
//   decr_i         : a flit was sent this cycle (only when count > 0)
//   credit_en_o    : count != 0
//   credit_cnt_o   : current count, resets to BUF_DEPTH
//   overflow_err_o : sticky, set by a return while already full
module noc_credit_counter #(
  parameter int BUF_DEPTH = 4,
  parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          incr_i,
  input  logic          decr_i,
  output logic          credit_en_o,
  output logic [CW-1:0] credit_cnt_o,
  output logic          overflow_err_o
);

  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  logic [CW-1:0] cnt;
  logic          err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= FULL;
      err <= 1'b0;
    end else begin
      unique case ({incr_i, decr_i})
        2'b10: begin
          if (cnt == FULL) err <= 1'b1;
          else             cnt <= cnt + 1'b1;
        end
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign credit_en_o    = (cnt != '0);
  assign credit_cnt_o   = cnt;
  assign overflow_err_o = err;

endmodule

// File: rtl/noc_outport_arbiter.sv
// Output-port scheduler for one NoC router output channel.
// Round-robin arbitration over NUM_PORTS requesters with wormhole locking:
// a requester granted a non-tail flit owns the channel until its tail flit.
// Every transfer is gated on downstream credit.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of noc_outport_arbiter_if (requests, tails,
//              credit returns in; grant, status and credit state out)
module noc_outport_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = NOC_NUM_PORTS,
  parameter int BUF_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  noc_outport_arbiter_if.slave   bus
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_t           state;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        owner;

  logic [PW-1:0]        winner;
  logic                 found;
  logic [PW-1:0]        cand;
  int unsigned          pos;
  logic [NUM_PORTS-1:0] grant;
  logic                 credit_en;
  logic [CW-1:0]        credit_cnt;
  logic                 overflow_err;
  logic                 sent;

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
    return (32'(p) == NUM_PORTS - 1) ? '0 : p + 1'b1;
  endfunction

  // First requester at or after rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    pos    = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      pos  = (32'(rr_ptr) + i) % NUM_PORTS;
      cand = PW'(pos);
      if (!found && bus.req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Zero-latency grant; reset forces it low regardless of state.
  always_comb begin
    grant = '0;
    if (rst && credit_en) begin
      if (state == ARB_IDLE) begin
        if (found) grant[winner] = 1'b1;
      end else if (bus.req_i[owner]) begin
        grant[owner] = 1'b1;
      end
    end
  end

  assign sent = |grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ARB_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (sent) begin
            if (bus.tail_i[winner]) begin
              rr_ptr <= next_port(winner);
            end else begin
              owner <= winner;
              state <= ARB_LOCKED;
            end
          end
        end
        ARB_LOCKED: begin
          if (sent && bus.tail_i[owner]) begin
            rr_ptr <= next_port(owner);
            state  <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  noc_credit_counter #(
    .BUF_DEPTH (BUF_DEPTH),
    .CW        (CW)
  ) u_credit (
    .clk            (clk),
    .rst            (rst),
    .incr_i         (bus.credit_ret_i),
    .decr_i         (sent),
    .credit_en_o    (credit_en),
    .credit_cnt_o   (credit_cnt),
    .overflow_err_o (overflow_err)
  );

  assign bus.grant_o        = grant;
  assign bus.flit_sent_o    = sent;
  assign bus.locked_o       = (state == ARB_LOCKED);
  assign bus.credit_en_o    = credit_en;
  assign bus.credit_cnt_o   = credit_cnt;
  assign bus.overflow_err_o = overflow_err;

endmodule

// File: tb/tb_noc_outport_arbiter.sv
// Directed table-driven bench for noc_outport_arbiter.
module tb_noc_outport_arbiter;
  import noc_pkg::*;

  localparam int NP = 5;
  localparam int BD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  noc_outport_arbiter_if #(.NUM_PORTS(NP), .BUF_DEPTH(BD)) bus ();

  noc_outport_arbiter #(.NUM_PORTS(NP), .BUF_DEPTH(BD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0] req;
    logic [4:0] tail;
    logic       ret;
    logic [4:0] grant;
    logic       locked;
    logic [2:0] cnt;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [4:0] req, input logic [4:0] tail,
                              input logic ret, input logic [4:0] grant,
                              input logic locked, input logic [2:0] cnt,
                              input logic err);
    vec_t v;
    v.req = req; v.tail = tail; v.ret = ret; v.grant = grant;
    v.locked = locked; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " grant"},  32'(bus.grant_o), 32'(v.grant));
    chk({tag, " sent"},   32'(bus.flit_sent_o), 32'(|v.grant));
    chk({tag, " locked"}, 32'(bus.locked_o), 32'(v.locked));
    chk({tag, " cnt"},    32'(bus.credit_cnt_o), 32'(v.cnt));
    chk({tag, " en"},     32'(bus.credit_en_o), 32'(v.cnt != 0));
    chk({tag, " err"},    32'(bus.overflow_err_o), 32'(v.err));
  endtask

  initial begin
    // Wormhole packet from port S, port N joins while it is locked
    vecs.push_back(mk(5'b00100, 5'b00000, 0, 5'b00100, 0, 4, 0));
    vecs.push_back(mk(5'b00101, 5'b00000, 0, 5'b00100, 1, 3, 0));
    vecs.push_back(mk(5'b00101, 5'b00100, 0, 5'b00100, 1, 2, 0));
    vecs.push_back(mk(5'b00001, 5'b00001, 0, 5'b00001, 0, 1, 0));
    vecs.push_back(mk(5'b00000, 5'b00000, 0, 5'b00000, 0, 0, 0));
    // Refill credits
    vecs.push_back(mk(5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0));
    vecs.push_back(mk(5'b00000, 5'b00000, 1, 5'b00000, 0, 1, 0));
    vecs.push_back(mk(5'b00000, 5'b00000, 1, 5'b00000, 0, 2, 0));
    vecs.push_back(mk(5'b00000, 5'b00000, 1, 5'b00000, 0, 3, 0));
    vecs.push_back(mk(5'b00000, 5'b00000, 0, 5'b00000, 0, 4, 0));
    // Round robin over single-flit packets, rr_ptr=1, send+return each cycle
    vecs.push_back(mk(5'b10011, 5'b11111, 1, 5'b00010, 0, 4, 0));
    vecs.push_back(mk(5'b10011, 5'b11111, 1, 5'b10000, 0, 4, 0));
    vecs.push_back(mk(5'b10011, 5'b11111, 1, 5'b00001, 0, 4, 0));
    vecs.push_back(mk(5'b10011, 5'b11111, 1, 5'b00010, 0, 4, 0));
    vecs.push_back(mk(5'b10011, 5'b11111, 1, 5'b10000, 0, 4, 0));
    // Port E streams until out of credit (rr_ptr=0)
    vecs.push_back(mk(5'b00010, 5'b00000, 0, 5'b00010, 0, 4, 0));
    vecs.push_back(mk(5'b00010, 5'b00000, 0, 5'b00010, 1, 3, 0));
    vecs.push_back(mk(5'b00010, 5'b00000, 0, 5'b00010, 1, 2, 0));
    vecs.push_back(mk(5'b00010, 5'b00000, 0, 5'b00010, 1, 1, 0));
    vecs.push_back(mk(5'b00010, 5'b00000, 0, 5'b00000, 1, 0, 0));
    vecs.push_back(mk(5'b00010, 5'b00000, 1, 5'b00000, 1, 0, 0));
    vecs.push_back(mk(5'b00010, 5'b00000, 0, 5'b00010, 1, 1, 0));
    vecs.push_back(mk(5'b00010, 5'b00000, 1, 5'b00000, 1, 0, 0));
    vecs.push_back(mk(5'b00010, 5'b00000, 1, 5'b00010, 1, 1, 0));
    vecs.push_back(mk(5'b00010, 5'b00000, 0, 5'b00010, 1, 1, 0));
    vecs.push_back(mk(5'b00000, 5'b00000, 1, 5'b00000, 1, 0, 0));
    vecs.push_back(mk(5'b00010, 5'b00010, 0, 5'b00010, 1, 1, 0));
    vecs.push_back(mk(5'b00000, 5'b00000, 0, 5'b00000, 0, 0, 0));
    // Refill, then overflow by returning while full
    vecs.push_back(mk(5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0));
    vecs.push_back(mk(5'b00000, 5'b00000, 1, 5'b00000, 0, 1, 0));
    vecs.push_back(mk(5'b00000, 5'b00000, 1, 5'b00000, 0, 2, 0));
    vecs.push_back(mk(5'b00000, 5'b00000, 1, 5'b00000, 0, 3, 0));
    vecs.push_back(mk(5'b00000, 5'b00000, 1, 5'b00000, 0, 4, 0));
    vecs.push_back(mk(5'b00000, 5'b00000, 0, 5'b00000, 0, 4, 1));
    vecs.push_back(mk(5'b00000, 5'b00000, 0, 5'b00000, 0, 4, 1));

    // Reset with all requests asserted
    bus.req_i = 5'b11111; bus.tail_i = 5'b11111; bus.credit_ret_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_all("reset", mk(5'b11111, 5'b11111, 0, 5'b00000, 0, 4, 0));
    @(negedge clk);
    bus.req_i = '0; bus.tail_i = '0;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.req_i        = vecs[i].req;
      bus.tail_i       = vecs[i].tail;
      bus.credit_ret_i = vecs[i].ret;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i]);
      @(posedge clk); #1;
    end

    // Reset in the middle of a packet (rr_ptr=2, so port W wins)
    bus.req_i = 5'b01000; bus.tail_i = '0; bus.credit_ret_i = 1'b0;
    @(negedge clk);
    chk("midpkt grant", 32'(bus.grant_o), 32'h08);
    @(posedge clk); #1;
    chk("midpkt locked", 32'(bus.locked_o), 32'd1);
    chk("midpkt cnt", 32'(bus.credit_cnt_o), 32'd3);
    chk("midpkt err", 32'(bus.overflow_err_o), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk_all("async_rst", mk(5'b01000, 5'b00000, 0, 5'b00000, 0, 4, 0));
    @(negedge clk);
    rst = 1'b1;
    bus.req_i = 5'b11111; bus.tail_i = 5'b11111;
    #1;
    chk("post_rst grant", 32'(bus.grant_o), 32'h01);
    @(posedge clk); #1;
    chk("post_rst locked", 32'(bus.locked_o), 32'd0);
    chk("post_rst cnt", 32'(bus.credit_cnt_o), 32'd3);
    chk("post_rst next grant", 32'(bus.grant_o), 32'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
